// File: rtl/rvv_backend_cmdq_mpq.sv
// rtl/rvv_backend_cmdq_mpq.sv - multi-push / multi-pop command queue between RVS issue and decoder
module rvv_backend_cmdq_mpq #(
    parameter int DEPTH    = 16,
    parameter int DWIDTH   = 32,
    parameter int PUSH_N   = 4,
    parameter int POP_N    = 2,
    parameter int AF_LEVEL = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [PUSH_N-1:0]                push_valid,
    input  logic [PUSH_N-1:0][DWIDTH-1:0]    push_data,
    output logic [PUSH_N-1:0]                push_ready,
    output logic [POP_N-1:0]                 pop_valid,
    output logic [POP_N-1:0][DWIDTH-1:0]     pop_data,
    input  logic [POP_N-1:0]                 pop_ready,
    input  logic                             stop,
    input  logic                             flush,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]     free;
    logic [CW-1:0]     n_push;
    logic [CW-1:0]     n_pop;
    logic              push_run;
    logic              pop_run;

    // Space is judged on registered occupancy only; same-cycle pops never free room.
    assign free        = CW'(DEPTH) - count;
    assign almost_full = (count >= CW'(AF_LEVEL));

    always_comb begin
        n_push   = '0;
        push_run = 1'b1;
        for (int i = 0; i < PUSH_N; i++) begin
            push_ready[i] = rst_n & ~stop & ~flush & (free > CW'(i));
            if (push_run && push_valid[i] && push_ready[i]) begin
                n_push = n_push + CW'(1);
            end else begin
                push_run = 1'b0;
            end
        end
    end

    always_comb begin
        n_pop   = '0;
        pop_run = 1'b1;
        for (int j = 0; j < POP_N; j++) begin
            pop_valid[j] = rst_n & (count > CW'(j));
            pop_data[j]  = mem[rd_ptr + AW'(j)];
            if (pop_run && pop_valid[j] && pop_ready[j]) begin
                n_pop = n_pop + CW'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            rd_ptr <= rd_ptr + n_pop[AW-1:0];
            count  <= count + n_push - n_pop;
        end
    end

    // Storage is not reset; n_push is already zero during reset and flush.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_N; k++) begin
            if (CW'(k) < n_push) begin
                mem[wr_ptr + AW'(k)] <= push_data[k];
            end
        end
    end

endmodule

// File: tb/tb_rvv_backend_cmdq_mpq.sv
// tb/tb_rvv_backend_cmdq_mpq.sv - self-checking bench for rvv_backend_cmdq_mpq
module tb_rvv_backend_cmdq_mpq;

    logic             clk;
    logic             rst_n;
    logic [3:0]       push_valid;
    logic [3:0][31:0] push_data;
    logic [3:0]       push_ready;
    logic [1:0]       pop_valid;
    logic [1:0][31:0] pop_data;
    logic [1:0]       pop_ready;
    logic             stop;
    logic             flush;
    logic [4:0]       count;
    logic             almost_full;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 0;
    logic [31:0] q[$];

    rvv_backend_cmdq_mpq #(.DEPTH(16), .DWIDTH(32), .PUSH_N(4), .POP_N(2), .AF_LEVEL(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
        .stop(stop), .flush(flush), .count(count), .almost_full(almost_full)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_pr();
        int free = 16 - q.size();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = rst_n && !stop && !flush && (free > i);
        return r;
    endfunction

    function automatic logic [1:0] m_pv();
        logic [1:0] r;
        for (int j = 0; j < 2; j++) r[j] = rst_n && (q.size() > j);
        return r;
    endfunction

    // Called at edge+1; applies inputs and checks outputs at the falling edge.
    task automatic drive_check(input logic [3:0] pv, input logic [3:0][31:0] pd,
                               input logic [1:0] prd, input logic stp, input logic fl, input logic rn);
        push_valid = pv; push_data = pd; pop_ready = prd;
        stop = stp; flush = fl; rst_n = rn;
        #4;
        if (chk_en) begin
            check("push_ready", 32'(push_ready), 32'(m_pr()));
            check("pop_valid", 32'(pop_valid), 32'(m_pv()));
            for (int j = 0; j < 2; j++)
                if (rst_n && q.size() > j) check("pop_data", pop_data[j], q[j]);
            check("count", 32'(count), 32'(q.size()));
            check("almost_full", 32'(almost_full), 32'(q.size() >= 12));
        end
    endtask

    task automatic advance();
        logic [3:0] pr = m_pr();
        logic [1:0] pv = m_pv();
        int np = 0, nq = 0;
        while (np < 4 && push_valid[np] && pr[np]) np++;
        while (nq < 2 && pop_ready[nq] && pv[nq]) nq++;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            for (int j = 0; j < nq; j++) void'(q.pop_front());
            for (int k = 0; k < np; k++) q.push_back(push_data[k]);
        end
        #1;
    endtask

    task automatic step(input logic [3:0] pv, input logic [3:0][31:0] pd,
                        input logic [1:0] prd, input logic stp, input logic fl);
        drive_check(pv, pd, prd, stp, fl, 1'b1);
        advance();
    endtask

    function automatic logic [3:0][31:0] seq(input logic [31:0] base);
        logic [3:0][31:0] r;
        for (int i = 0; i < 4; i++) r[i] = base + 32'(i);
        return r;
    endfunction

    initial begin
        logic [3:0][31:0] rd;
        push_valid = '0; push_data = '0; pop_ready = '0; stop = 0; flush = 0; rst_n = 0;
        #1;
        drive_check(4'h0, '0, 2'b00, 0, 0, 0);
        advance();
        chk_en = 1;
        drive_check(4'h0, '0, 2'b00, 0, 0, 0);
        advance();

        // Reset values and first 4-lane push
        drive_check(4'hF, seq(32'h10), 2'b00, 0, 0, 1);
        check("rst_count", 32'(count), 0);
        check("rst_push_ready", 32'(push_ready), 32'hF);
        check("rst_pop_valid", 32'(pop_valid), 0);
        advance();
        check("p4_count", 32'(count), 4);
        check("p4_pop_valid", 32'(pop_valid), 32'h3);
        check("p4_pop_data0", pop_data[0], 32'h10);
        check("p4_pop_data1", pop_data[1], 32'h11);
        check("p4_af", 32'(almost_full), 0);

        // Fill to 14, then 4 pushes with 2 pops
        step(4'hF, seq(32'h20), 2'b00, 0, 0);
        step(4'hF, seq(32'h30), 2'b00, 0, 0);
        step(4'h3, seq(32'h40), 2'b00, 0, 0);
        drive_check(4'hF, seq(32'h50), 2'b11, 0, 0, 1);
        check("full14_count", 32'(count), 14);
        check("full14_push_ready", 32'(push_ready), 32'h3);
        check("full14_pop0", pop_data[0], 32'h10);
        check("full14_pop1", pop_data[1], 32'h11);
        check("full14_af", 32'(almost_full), 1);
        advance();
        check("after_count", 32'(count), 14);
        check("after_pop0", pop_data[0], 32'h12);

        // Gap in valid lanes: only lane 0 written
        rd = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'h60};
        step(4'b1101, rd, 2'b00, 0, 0);
        check("gap_count", 32'(count), 15);
        for (int c = 0; c < 10; c++) step(4'h0, '0, 2'b11, 0, 0);
        check("drain_count", 32'(count), 0);

        // Wrap: bring both pointers to 14 while empty
        step(4'h0, '0, 2'b00, 0, 1);
        for (int c = 0; c < 7; c++) step(4'h3, seq(32'h100 + 32'(c * 4)), 2'b11, 0, 0);
        step(4'h0, '0, 2'b11, 0, 0);
        check("wrap_empty", 32'(count), 0);
        step(4'hF, seq(32'hA0), 2'b00, 0, 0);
        drive_check(4'h0, '0, 2'b11, 0, 0, 1);
        check("wrap_pop0", pop_data[0], 32'hA0);
        check("wrap_pop1", pop_data[1], 32'hA1);
        advance();
        drive_check(4'h0, '0, 2'b11, 0, 0, 1);
        check("wrap_pop2", pop_data[0], 32'hA2);
        check("wrap_pop3", pop_data[1], 32'hA3);
        advance();
        check("wrap_count", 32'(count), 0);

        // Stop drains the queue
        step(4'hF, seq(32'h200), 2'b00, 0, 0);
        step(4'h3, seq(32'h210), 2'b00, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive_check(4'hF, seq(32'h300), 2'b11, 1, 0, 1);
            check("stop_push_ready", 32'(push_ready), 0);
            check("stop_count", 32'(count), 32'(6 - 2 * c));
            advance();
        end
        check("stop_final", 32'(count), 0);

        // Flush with simultaneous push and pop
        step(4'hF, seq(32'h400), 2'b00, 0, 0);
        step(4'hF, seq(32'h410), 2'b00, 0, 0);
        step(4'h1, seq(32'h420), 2'b00, 0, 0);
        drive_check(4'hF, seq(32'h500), 2'b11, 0, 1, 1);
        check("flush_count_pre", 32'(count), 9);
        check("flush_push_ready", 32'(push_ready), 0);
        advance();
        check("flush_count", 32'(count), 0);
        check("flush_pop_valid", 32'(pop_valid), 0);
        check("flush_af", 32'(almost_full), 0);
        step(4'h1, {32'h0, 32'h0, 32'h0, 32'hAA}, 2'b00, 0, 0);
        check("flush_aa", pop_data[0], 32'hAA);

        // Randomized traffic against the queue model
        for (int c = 0; c < 3000; c++) begin
            logic [3:0][31:0] pd;
            for (int i = 0; i < 4; i++) pd[i] = $urandom;
            drive_check(4'($urandom), pd, 2'($urandom),
                        ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                        ($urandom_range(0, 99) != 0));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
